// File: rtl/nand_page_copier.sv
// Purpose : copies pages [start_page, start_page+num_pages) from flash A to the same pages on flash B.
// Latency : per page 2+2(C+R)+T (read) + 2+2(C+R) + 2(PAGE_BYTES+1) + 2+T + 2+T+2 (status) + 1 cycles at ideal RB.
// Backpr. : waits indefinitely on RB low; a start while busy is ignored; registered pins only.
// Ports   : clk/rst (sync, active-high); start/start_page/num_pages request; busy/done status;
//           fail_count/fail_page status-failure log; F_*_A / F_*_B raw NAND pin interfaces (RB 1 = ready).
module nand_page_copier #(
  parameter int PAGE_BYTES   = 512,
  parameter int PAGE_AW      = 9,
  parameter int COL_CYCLES   = 1,
  parameter int ROW_CYCLES   = 2,
  parameter int TWB_CYC      = 2,
  parameter int STATUS_CHECK = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PAGE_AW-1:0] start_page,
  input  logic [PAGE_AW:0]   num_pages,
  output logic               busy,
  output logic               done,
  output logic [PAGE_AW:0]   fail_count,
  output logic [PAGE_AW-1:0] fail_page,
  inout  wire  [7:0]         F_IO_A,
  output logic               F_CLE_A,
  output logic               F_ALE_A,
  output logic               F_REN_A,
  output logic               F_WEN_A,
  input  logic               F_RB_A,
  inout  wire  [7:0]         F_IO_B,
  output logic               F_CLE_B,
  output logic               F_ALE_B,
  output logic               F_REN_B,
  output logic               F_WEN_B,
  input  logic               F_RB_B
);
  localparam int ADDR_N = COL_CYCLES + ROW_CYCLES;
  localparam int RW     = (8 * ROW_CYCLES > PAGE_AW) ? 8 * ROW_CYCLES : PAGE_AW;
  localparam int CW     = $clog2(PAGE_BYTES + ADDR_N + TWB_CYC + 2) + 1;

  typedef enum logic [3:0] {
    IDLE, A_CMD, A_ADDR, A_WAIT, B_CMD, B_ADDR, XFER,
    B_CFM, B_BUSY, B_STAT, B_SRD, NEXT, FIN
  } state_t;

  // One flash pin bundle; oe is the registered IO tri-state enable.
  typedef struct packed {
    logic       cle;
    logic       ale;
    logic       wen;
    logic       ren;
    logic       oe;
    logic [7:0] io;
  } pins_t;

  localparam pins_t PINS_IDLE = '{cle: 1'b0, ale: 1'b0, wen: 1'b1, ren: 1'b1, oe: 1'b1, io: 8'h00};

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               ph, ph_nx;          // 0 = WEN/REN-low half of a 2-cycle slot
  logic [PAGE_AW-1:0] cur, cur_nx;
  logic [PAGE_AW:0]   rem, rem_nx;
  logic [7:0]         data_reg, data_nx;
  logic               busy_nx, done_nx;
  logic [PAGE_AW:0]   fc_nx;
  logic [PAGE_AW-1:0] fp_nx;
  pins_t              pa, pa_nx, pb, pb_nx;

  // Address byte idx: column bytes are zero, row byte k is page[8k+7:8k].
  function automatic logic [7:0] addr_byte(input logic [CW-1:0] idx, input logic [PAGE_AW-1:0] pg);
    logic [RW-1:0] row;
    addr_byte = 8'h00;
    row = RW'(pg);
    if (int'(idx) >= COL_CYCLES) begin
      row = row >> (8 * (int'(idx) - COL_CYCLES));
      addr_byte = row[7:0];
    end
  endfunction

  // Pin values computed here appear on the pins one cycle later, so every
  // pin shares the same one-cycle lag behind the state register.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ph_nx    = ph;
    cur_nx   = cur;
    rem_nx   = rem;
    data_nx  = data_reg;
    busy_nx  = busy;
    done_nx  = done;
    fc_nx    = fail_count;
    fp_nx    = fail_page;
    pa_nx    = PINS_IDLE;
    pb_nx    = PINS_IDLE;
    case (state)
      IDLE: if (start) begin
        cur_nx   = start_page;
        rem_nx   = num_pages;
        busy_nx  = 1'b1;
        done_nx  = 1'b0;
        fc_nx    = '0;
        fp_nx    = '0;
        cnt_nx   = '0;
        ph_nx    = 1'b0;
        state_nx = (num_pages == '0) ? FIN : A_CMD;
      end
      A_CMD: begin
        pa_nx.cle = 1'b1;
        pa_nx.io  = 8'h00;
        pa_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) state_nx = A_ADDR;
      end
      A_ADDR: begin
        pa_nx.ale = 1'b1;
        pa_nx.io  = addr_byte(cnt, cur);
        pa_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) begin
          if (cnt == CW'(ADDR_N - 1)) begin
            cnt_nx   = '0;
            state_nx = A_WAIT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      A_WAIT: begin
        if (cnt != CW'(TWB_CYC - 1)) cnt_nx = cnt + 1'b1;
        else if (F_RB_A) begin
          cnt_nx   = '0;
          state_nx = B_CMD;
        end
      end
      B_CMD: begin
        pb_nx.cle = 1'b1;
        pb_nx.io  = 8'h80;
        pb_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) state_nx = B_ADDR;
      end
      B_ADDR: begin
        pb_nx.ale = 1'b1;
        pb_nx.io  = addr_byte(cnt, cur);
        pb_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) begin
          if (cnt == CW'(ADDR_N - 1)) begin
            cnt_nx   = '0;
            state_nx = XFER;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      XFER: begin
        // Slot k reads byte k from A and writes byte k-1 (held in data_reg) to B.
        pa_nx.oe = 1'b0;
        pb_nx.io = data_reg;
        ph_nx    = ~ph;
        if (!ph) begin
          pa_nx.ren = (cnt >= CW'(PAGE_BYTES));
          pb_nx.wen = (cnt == '0);
        end else begin
          if (cnt < CW'(PAGE_BYTES)) data_nx = F_IO_A;
          if (cnt == CW'(PAGE_BYTES)) begin
            cnt_nx   = '0;
            state_nx = B_CFM;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      B_CFM: begin
        pb_nx.cle = 1'b1;
        pb_nx.io  = 8'h10;
        pb_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) state_nx = B_BUSY;
      end
      B_BUSY: begin
        if (cnt != CW'(TWB_CYC - 1)) cnt_nx = cnt + 1'b1;
        else if (F_RB_B) begin
          cnt_nx   = '0;
          state_nx = (STATUS_CHECK != 0) ? B_STAT : NEXT;
        end
      end
      B_STAT: begin
        pb_nx.cle = 1'b1;
        pb_nx.io  = 8'h70;
        pb_nx.wen = ph;
        ph_nx     = ~ph;
        if (ph) state_nx = B_SRD;
      end
      B_SRD: begin
        pb_nx.oe = 1'b0;
        if (cnt != CW'(TWB_CYC)) cnt_nx = cnt + 1'b1;
        else begin
          pb_nx.ren = ph;
          ph_nx     = ~ph;
          if (ph) begin
            data_nx = F_IO_B;
            if (F_IO_B[0]) begin
              if (!(&fail_count)) fc_nx = fail_count + 1'b1;
              if (fail_count == '0) fp_nx = cur;
            end
            cnt_nx   = '0;
            state_nx = NEXT;
          end
        end
      end
      NEXT: begin
        cur_nx   = cur + 1'b1;
        rem_nx   = rem - 1'b1;
        state_nx = (rem == (PAGE_AW + 1)'(1)) ? FIN : A_CMD;
      end
      FIN: begin
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ph         <= 1'b0;
      cur        <= '0;
      rem        <= '0;
      data_reg   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_count <= '0;
      fail_page  <= '0;
      pa         <= PINS_IDLE;
      pb         <= PINS_IDLE;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ph         <= ph_nx;
      cur        <= cur_nx;
      rem        <= rem_nx;
      data_reg   <= data_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      fail_count <= fc_nx;
      fail_page  <= fp_nx;
      pa         <= pa_nx;
      pb         <= pb_nx;
    end
  end

  assign F_CLE_A = pa.cle;
  assign F_ALE_A = pa.ale;
  assign F_WEN_A = pa.wen;
  assign F_REN_A = pa.ren;
  assign F_IO_A  = pa.oe ? pa.io : 8'hzz;
  assign F_CLE_B = pb.cle;
  assign F_ALE_B = pb.ale;
  assign F_WEN_B = pb.wen;
  assign F_REN_B = pb.ren;
  assign F_IO_B  = pb.oe ? pb.io : 8'hzz;

endmodule

// File: tb/tb_nand_page_copier.sv
// Purpose : self-checking bench for nand_page_copier with behavioural flash A/B models.
// Latency : expected pin streams are built per page from the copy rules, not from cycle timing.
// Backpr. : RB busy windows are injected on both flashes; every wait is bounded.
module tb_nand_page_copier;
  localparam int PB = 512;
  localparam int PLEN = 1 + 3 + PB + 2;   // B latch events per page

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] start_page;
  logic [9:0] num_pages;
  logic       busy, done;
  logic [9:0] fail_count;
  logic [8:0] fail_page;
  wire  [7:0] F_IO_A, F_IO_B;
  logic       F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A;
  logic       F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B;
  logic       rb_a, rb_b;

  nand_page_copier #(
    .PAGE_BYTES(PB), .PAGE_AW(9), .COL_CYCLES(1), .ROW_CYCLES(2), .TWB_CYC(2), .STATUS_CHECK(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_page(start_page), .num_pages(num_pages),
    .busy(busy), .done(done), .fail_count(fail_count), .fail_page(fail_page),
    .F_IO_A(F_IO_A), .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A), .F_REN_A(F_REN_A),
    .F_WEN_A(F_WEN_A), .F_RB_A(rb_a),
    .F_IO_B(F_IO_B), .F_CLE_B(F_CLE_B), .F_ALE_B(F_ALE_B), .F_REN_B(F_REN_B),
    .F_WEN_B(F_WEN_B), .F_RB_B(rb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Content of flash A: byte i of page p.
  function automatic logic [7:0] fdat(input logic [8:0] p, input int i, input logic [7:0] s);
    logic [7:0] ib;
    ib = i[7:0];
    return (ib + p[7:0] * 8'd7) ^ s;
  endfunction

  // Latch events are {CLE, ALE, IO}.
  logic [9:0]  exp_a[$];
  logic [9:0]  exp_b[$];
  logic [9:0]  log_b[$];
  logic [7:0]  run_salt = 8'h00;
  logic [8:0]  a_page = 9'd0;
  int          a_idx = 0;
  int          a_addr_n = 0;
  logic [31:0] fail_mask = 32'd0;
  int          prog_n = 0;
  logic [7:0]  b_status = 8'hE0;
  int          a_busy = 0, b_busy = 0, hold_a = 0, hold_b = 0;
  int          ren_a_lows = 0, ren_busy = 0, pin_act = 0;
  logic        pw_a = 1'b1, pw_b = 1'b1, pr_a = 1'b1;
  logic [7:0]  a_data;

  assign a_data = fdat(a_page, a_idx, run_salt);
  assign F_IO_A = F_REN_A ? 8'hzz : a_data;
  assign F_IO_B = F_REN_B ? 8'hzz : b_status;

  task automatic push_page(input logic [8:0] p, input logic [7:0] s);
    exp_a.push_back(10'h200);
    exp_a.push_back(10'h100);
    exp_a.push_back({2'b01, p[7:0]});
    exp_a.push_back({2'b01, 7'd0, p[8]});
    exp_b.push_back(10'h280);
    exp_b.push_back(10'h100);
    exp_b.push_back({2'b01, p[7:0]});
    exp_b.push_back({2'b01, 7'd0, p[8]});
    for (int i = 0; i < PB; i++) exp_b.push_back({2'b00, fdat(p, i, s)});
    exp_b.push_back(10'h210);
    exp_b.push_back(10'h270);
  endtask

  // Flash models and the per-cycle compare process.
  initial begin
    logic [9:0] v, e;
    forever begin
      @(negedge clk);
      if (a_busy > 0) begin a_busy--; if (a_busy == 0) rb_a = 1'b1; end
      if (b_busy > 0) begin b_busy--; if (b_busy == 0) rb_b = 1'b1; end
      if (!rst) begin
        if (!F_WEN_A || !F_WEN_B || !F_REN_A || !F_REN_B ||
            F_CLE_A || F_ALE_A || F_CLE_B || F_ALE_B) pin_act++;
        if (!F_REN_A) begin
          ren_a_lows++;
          if (!rb_a) ren_busy++;
        end
        if (!pw_a && F_WEN_A) begin
          v = {F_CLE_A, F_ALE_A, F_IO_A};
          if (exp_a.size() > 0) e = exp_a.pop_front(); else e = 10'h3FF;
          chk("a_latch", 32'(v), 32'(e));
          if (F_CLE_A && F_IO_A == 8'h00) begin a_addr_n = 0; a_idx = 0; end
          if (F_ALE_A) begin
            a_addr_n++;
            if (a_addr_n == 2) a_page[7:0] = F_IO_A;
            if (a_addr_n == 3) begin
              a_page[8] = F_IO_A[0];
              if (hold_a > 0) begin rb_a = 1'b0; a_busy = hold_a; end
            end
          end
        end
        if (!pr_a && F_REN_A) a_idx++;
        if (!pw_b && F_WEN_B) begin
          v = {F_CLE_B, F_ALE_B, F_IO_B};
          log_b.push_back(v);
          if (exp_b.size() > 0) e = exp_b.pop_front(); else e = 10'h3FF;
          chk("b_latch", 32'(v), 32'(e));
          if (v == 10'h210) begin
            prog_n++;
            b_status = fail_mask[prog_n-1] ? 8'hE1 : 8'hE0;
            if (hold_b > 0) begin rb_b = 1'b0; b_busy = hold_b; end
          end
        end
      end
      pw_a = F_WEN_A;
      pw_b = F_WEN_B;
      pr_a = F_REN_A;
    end
  end

  task automatic run_copy(input logic [8:0] sp, input int np, input logic [31:0] mask,
                          input logic [7:0] salt, input int ha, input int hb, input bit glitch);
    int         n, efc;
    logic [8:0] p, efp;
    efc = 0;
    efp = 9'd0;
    for (int j = 0; j < np; j++) begin
      p = sp + 9'(j);
      push_page(p, salt);
      if (mask[j]) begin
        if (efc == 0) efp = p;
        efc++;
      end
    end
    run_salt = salt; fail_mask = mask; prog_n = 0; hold_a = ha; hold_b = hb;
    log_b.delete(); ren_a_lows = 0; ren_busy = 0;
    @(posedge clk); #1;
    start = 1'b1; start_page = sp; num_pages = 10'(np);
    @(posedge clk); #1;
    start = 1'b0; start_page = 9'($urandom); num_pages = 10'($urandom);
    @(negedge clk);
    chk("busy_set", 32'(busy), 32'd1);
    chk("done_clr", 32'(done), 32'd0);
    if (glitch) begin
      repeat (50) @(posedge clk);
      #1; start = 1'b1; start_page = 9'd3; num_pages = 10'd7;
      @(posedge clk); #1; start = 1'b0;
    end
    n = 0;
    while (!done && n < 30000) begin @(negedge clk); n++; end
    chk("done_timeout", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("fail_count", 32'(fail_count), 32'(efc));
    chk("fail_page", 32'(fail_page), 32'(efp));
    chk("a_left", 32'(exp_a.size()), 32'd0);
    chk("b_left", 32'(exp_b.size()), 32'd0);
    chk("ren_a_count", 32'(ren_a_lows), 32'(np * PB));
    chk("ren_while_rb_low", 32'(ren_busy), 32'd0);
  endtask

  initial begin
    int n, k;
    rst = 1'b1; start = 1'b0; start_page = 9'd0; num_pages = 10'd0;
    rb_a = 1'b1; rb_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fc", 32'(fail_count), 32'd0);
    chk("rst_fp", 32'(fail_page), 32'd0);
    chk("rst_pins", 32'({F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B}),
        32'h33);
    chk("rst_io", 32'({F_IO_A, F_IO_B}), 32'h0000);
    @(posedge clk); #1; rst = 1'b0;

    // Single page 0, A byte i = i.
    run_copy(9'd0, 1, 32'd0, 8'h00, 0, 0, 1'b0);
    chk("t1_len", 32'(log_b.size()), 32'(PLEN));
    chk("t1_cmd", 32'(log_b[0]), 32'h280);
    chk("t1_row1", 32'(log_b[3]), 32'h100);
    chk("t1_b0", 32'(log_b[4]), 32'h000);
    chk("t1_b255", 32'(log_b[4+255]), 32'h0FF);
    chk("t1_b256", 32'(log_b[4+256]), 32'h000);
    chk("t1_b511", 32'(log_b[4+511]), 32'h0FF);
    chk("t1_cfm", 32'(log_b[516]), 32'h210);
    chk("t1_stat", 32'(log_b[517]), 32'h270);
    chk("t1_done", 32'(done), 32'd1);

    // Wrap 510, 511, 0 with an ignored start while busy.
    run_copy(9'd510, 3, 32'd0, 8'h00, 0, 0, 1'b1);
    chk("t2_len", 32'(log_b.size()), 32'(3 * PLEN));
    chk("t2_p511_row0", 32'(log_b[PLEN+2]), 32'h1FF);
    chk("t2_p511_row1", 32'(log_b[PLEN+3]), 32'h101);
    chk("t2_p0_row0", 32'(log_b[2*PLEN+2]), 32'h100);
    chk("t2_p0_row1", 32'(log_b[2*PLEN+3]), 32'h100);

    // Status failure on the second of four pages.
    run_copy(9'd5, 4, 32'h2, 8'h96, 0, 0, 1'b0);
    chk("t3_fc_lit", 32'(fail_count), 32'd1);
    chk("t3_fp_lit", 32'(fail_page), 32'd6);

    // RB_A held low 100 cycles after the read address.
    run_copy(9'd300, 1, 32'd0, 8'h21, 100, 0, 1'b0);

    // Reset in the middle of the transfer.
    push_page(9'd40, 8'h33);
    run_salt = 8'h33; fail_mask = 32'd0; prog_n = 0; hold_a = 0; hold_b = 0; log_b.delete();
    @(posedge clk); #1; start = 1'b1; start_page = 9'd40; num_pages = 10'd1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (log_b.size() < 4 + 200 && n < 5000) begin @(posedge clk); n++; end
    chk("t5_reach", 32'(log_b.size() >= 4 + 200), 32'd1);
    #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_pins", 32'({F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B}),
        32'h33);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete(); exp_b.delete();
    rb_a = 1'b1; rb_b = 1'b1; a_busy = 0; b_busy = 0;
    run_copy(9'd41, 1, 32'd0, 8'hC5, 3, 2, 1'b0);

    // Zero pages: one busy cycle, then done, no pin activity.
    @(posedge clk); #1;
    start = 1'b1; start_page = 9'd7; num_pages = 10'd0; k = pin_act;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("t6_busy1", 32'(busy), 32'd1);
    chk("t6_done1", 32'(done), 32'd0);
    @(negedge clk);
    chk("t6_busy2", 32'(busy), 32'd0);
    chk("t6_done2", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_pins", 32'(pin_act - k), 32'd0);

    // Randomised ranges, contents, failures and RB busy windows.
    for (int r = 0; r < 3; r++) begin
      run_copy(9'($urandom_range(0, 511)), int'($urandom_range(1, 2)), $urandom,
               8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nand_page_copier.md
Name: nand_page_copier

Overview:
- Parametrised NAND page-copy engine. Copies a contiguous range of pages from flash A to the same page addresses in flash B, one page at a time: read 00h on A, program 80h/10h on B.
- New relative to the fixed 512×512 copier: start/range inputs, busy/done handshake, configurable page size and address cycles, and optional post-program status check (70h) with failure logging.
- Sits between the system controller and the two NAND pin interfaces.

Parameters:
- PAGE_BYTES, 512, data bytes transferred per page (≥1).
- PAGE_AW, 9, page address width.
- COL_CYCLES, 1, column address cycles; every column byte is 00h.
- ROW_CYCLES, 2, row address cycles; byte k = page[8k+7:8k], zero-extended above PAGE_AW.
- TWB_CYC, 2, cycles to wait after the last WEN rise before sampling RB (≥1).
- STATUS_CHECK, 1, 1 = issue 70h after each program and check status bit0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle request; accepted only when busy=0
- start_page  in  PAGE_AW  first page, captured on accepted start
- num_pages  in  PAGE_AW+1  page count, captured on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  level; high after completion, cleared by next accepted start
- fail_count  out  PAGE_AW+1  programs with status bit0=1 (saturating)
- fail_page  out  PAGE_AW  page address of the first failure
- F_IO_A  inout  8;  F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A  out  1;  F_RB_A  in  1 (1 = ready)
- F_IO_B  inout  8;  F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B  out  1;  F_RB_B  in  1

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset (also mid-operation, takes effect the next edge):
  - busy=0, done=0, fail_count=0, fail_page=0.
  - Both flashes: CLE=0, ALE=0, WEN=1, REN=1, IO driven 00h.
  - FSM goes to IDLE; any page in flight is abandoned.
- All pin outputs are registered. IO tri-state enables are registered.
- Latch pulse: one cycle WEN low with CLE/ALE/IO valid, then one cycle WEN high with the same values (2 cycles per command/address byte).
- FSM per page (cur = current page):
  - A_CMD: CLE_A=1, drive 00h.
  - A_ADDR: ALE_A=1, COL_CYCLES+ROW_CYCLES bytes using cur.
  - A_WAIT: wait TWB_CYC cycles, then stay until F_RB_A=1.
  - B_CMD: CLE_B=1, drive 80h.
  - B_ADDR: same address sequence on B.
  - XFER: A IO released; PAGE_BYTES+1 slots of 2 cycles each.
    - Slot k<PAGE_BYTES: REN_A low in the first cycle; F_IO_A sampled into data_reg on the edge ending that cycle.
    - Slot k>0: WEN_B low in the first cycle, F_IO_B = data_reg (byte k-1); WEN_B high in the second cycle.
    - Bytes never reorder.
  - B_CFM: CLE_B=1, 10h; A IO re-driven.
  - B_BUSY: wait TWB_CYC, then wait for F_RB_B=1.
  - B_STAT (STATUS_CHECK=1 only): CLE_B=1, 70h.
  - B_SRD: wait TWB_CYC, release B IO, REN_B low one cycle, sample F_IO_B[0], REN_B high.
    - If bit0=1: fail_count++ (saturates at all-ones); if fail_count was 0, fail_page=cur.
  - NEXT: cur = cur+1 modulo 2^PAGE_AW (wraps); remaining--; if remaining=0 go to DONE, else A_CMD.
- Accepted start: captures inputs, clears done, fail_count and fail_page, sets busy the next cycle.
- num_pages=0: busy for exactly one cycle, then done=1; no pin activity.
- start while busy: ignored.
- RB low for a long time: wait indefinitely; no timeout.
- Each RB wait requires RB=1 on a sample taken after the TWB_CYC window.
- Per-page latency with ideal ready (RB=1) and STATUS_CHECK=1, C=COL_CYCLES, R=ROW_CYCLES, T=TWB_CYC:
  - A: 2+2(C+R)+T
  - B setup: 2+2(C+R)
  - XFER: 2(PAGE_BYTES+1)
  - Confirm: 2+T
  - Status: 2+T+2
  - NEXT: 1

Test Plan:
- start_page=0, num_pages=1, PAGE_BYTES=512, A model returns byte i = i[7:0] -> B receives 80h, address 00h,00h,00h, then bytes 00h..FFh,00h..FFh, then 10h and 70h; done=1, fail_count=0.
- start_page=510, num_pages=3, PAGE_AW=9 -> pages 510, 511, 0 copied in order; B row bytes for page 0 are 00h,00h.
- B status returns 01h on the 2nd page of 4 (start_page=5) -> fail_count=1, fail_page=6; all 4 pages still copied.
- RB_A held low 100 cycles after the read address -> no REN_A falls until RB_A=1; XFER data is correct afterwards.
- rst asserted mid-XFER at byte 200 -> next cycle busy=0, WEN/REN=1, CLE/ALE=0; a new start copies a full page correctly.
- num_pages=0 -> done 2 cycles after start with no pin toggles; start pulsed while busy -> no effect on range.
